// File: rtl/st7789_spi_rx.sv
// Passive ST7789 display-bus receiver: decodes host SPI (mode 3, no CS) into
// command bytes and RGB565 pixels with the panel's window/address bookkeeping.
module st7789_spi_rx #(
  parameter int WIDTH        = 240,
  parameter int HEIGHT       = 240,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        st7789_SDA,
  input  logic        st7789_SCL,
  input  logic        st7789_DC,
  input  logic        st7789_RES,
  output logic        cmd_valid_o,
  output logic [7:0]  cmd_o,
  output logic        pix_valid_o,
  output logic [8:0]  pix_x_o,
  output logic [8:0]  pix_y_o,
  output logic [15:0] pix_data_o
);

  localparam int                IDLE_W    = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [8:0]        XE_RST    = 9'(WIDTH - 1);
  localparam logic [8:0]        YE_RST    = 9'(HEIGHT - 1);
  // Pin order {RES, DC, SCL, SDA}; SCL and RES idle high.
  localparam logic [3:0]        SYNC_RST  = 4'b1010;

  typedef enum logic [2:0] {IDLE, CASET, RASET, RAMWR, SKIP} state_t;

  logic [3:0] pins;
  logic [3:0] meta_q;
  logic [3:0] sync_q;
  logic       scl_prev_q;
  logic       sda_s;
  logic       scl_s;
  logic       dc_s;
  logic       res_s;
  logic       core_rst_n;
  logic       scl_rise;

  assign pins = {st7789_RES, st7789_DC, st7789_SCL, st7789_SDA};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q     <= SYNC_RST;
      sync_q     <= SYNC_RST;
      scl_prev_q <= 1'b1;
    end else begin
      meta_q     <= pins;
      sync_q     <= meta_q;
      scl_prev_q <= sync_q[1];
    end
  end

  assign sda_s      = sync_q[0];
  assign scl_s      = sync_q[1];
  assign dc_s       = sync_q[2];
  assign res_s      = sync_q[3];
  assign core_rst_n = rst_ni & res_s;
  assign scl_rise   = scl_s & ~scl_prev_q;

  // Bit assembly and idle realignment.
  logic [7:0]        shift_q;
  logic [2:0]        bit_cnt_q;
  logic [IDLE_W-1:0] idle_q;
  logic              byte_vld_q;
  logic              byte_dc_q;

  always_ff @(posedge clk_i) begin
    if (!core_rst_n) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      idle_q     <= '0;
      byte_vld_q <= 1'b0;
      byte_dc_q  <= 1'b0;
    end else begin
      byte_vld_q <= 1'b0;
      if (scl_rise) begin
        shift_q   <= {shift_q[6:0], sda_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        idle_q    <= '0;
        if (bit_cnt_q == 3'd7) begin
          byte_vld_q <= 1'b1;
          byte_dc_q  <= dc_s;
        end
      end else if (idle_q == IDLE_LAST) begin
        bit_cnt_q <= '0;
      end else begin
        idle_q <= idle_q + IDLE_W'(1);
      end
    end
  end

  // Extra stage so both pulses land exactly four cycles after the SCL sample.
  logic       byte2_vld_q;
  logic [7:0] byte2_q;
  logic       byte2_dc_q;

  always_ff @(posedge clk_i) begin
    if (!core_rst_n) begin
      byte2_vld_q <= 1'b0;
      byte2_q     <= '0;
      byte2_dc_q  <= 1'b0;
    end else begin
      byte2_vld_q <= byte_vld_q;
      if (byte_vld_q) begin
        byte2_q    <= shift_q;
        byte2_dc_q <= byte_dc_q;
      end
    end
  end

  // Command/data FSM.
  state_t      state_q, state_d;
  logic [1:0]  pcnt_q, pcnt_d;
  logic [8:0]  xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [8:0]  x_q, x_d, y_q, y_d;
  logic [7:0]  hi_q, hi_d;
  logic        half_q, half_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        pix_valid_q, pix_valid_d;
  logic [8:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [15:0] pix_data_q, pix_data_d;

  always_ff @(posedge clk_i) begin
    if (!core_rst_n) begin
      state_q     <= IDLE;
      pcnt_q      <= '0;
      xs_q        <= '0;
      xe_q        <= XE_RST;
      ys_q        <= '0;
      ye_q        <= YE_RST;
      x_q         <= '0;
      y_q         <= '0;
      hi_q        <= '0;
      half_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= '0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      xs_q        <= xs_d;
      xe_q        <= xe_d;
      ys_q        <= ys_d;
      ye_q        <= ye_d;
      x_q         <= x_d;
      y_q         <= y_d;
      hi_q        <= hi_d;
      half_q      <= half_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_data_q  <= pix_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pcnt_d      = pcnt_q;
    xs_d        = xs_q;
    xe_d        = xe_q;
    ys_d        = ys_q;
    ye_d        = ye_q;
    x_d         = x_q;
    y_d         = y_q;
    hi_d        = hi_q;
    half_d      = half_q;
    cmd_valid_d = 1'b0;
    cmd_d       = cmd_q;
    pix_valid_d = 1'b0;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_data_d  = pix_data_q;
    if (byte2_vld_q) begin
      if (!byte2_dc_q) begin
        cmd_valid_d = 1'b1;
        cmd_d       = byte2_q;
        pcnt_d      = '0;
        half_d      = 1'b0;
        case (byte2_q)
          8'h2A:   state_d = CASET;
          8'h2B:   state_d = RASET;
          8'h2C: begin
            state_d = RAMWR;
            x_d     = xs_q;
            y_d     = ys_q;
          end
          default: state_d = SKIP;
        endcase
      end else begin
        unique case (state_q)
          CASET, RASET: begin
            pcnt_d = pcnt_q + 2'd1;
            if (pcnt_q == 2'd3) state_d = IDLE;
            // Coordinates are 9 bits wide: only bit 0 of each high byte survives.
            if (state_q == CASET) begin
              case (pcnt_q)
                2'd0:    xs_d = {byte2_q[0], xs_q[7:0]};
                2'd1:    xs_d = {xs_q[8], byte2_q};
                2'd2:    xe_d = {byte2_q[0], xe_q[7:0]};
                default: xe_d = {xe_q[8], byte2_q};
              endcase
            end else begin
              case (pcnt_q)
                2'd0:    ys_d = {byte2_q[0], ys_q[7:0]};
                2'd1:    ys_d = {ys_q[8], byte2_q};
                2'd2:    ye_d = {byte2_q[0], ye_q[7:0]};
                default: ye_d = {ye_q[8], byte2_q};
              endcase
            end
          end
          RAMWR: begin
            if (!half_q) begin
              hi_d   = byte2_q;
              half_d = 1'b1;
            end else begin
              half_d      = 1'b0;
              pix_valid_d = 1'b1;
              pix_x_d     = x_q;
              pix_y_d     = y_q;
              pix_data_d  = {hi_q, byte2_q};
              if (x_q >= xe_q) begin
                x_d = xs_q;
                y_d = (y_q >= ye_q) ? ys_q : y_q + 9'd1;
              end else begin
                x_d = x_q + 9'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign cmd_valid_o = cmd_valid_q;
  assign cmd_o       = cmd_q;
  assign pix_valid_o = pix_valid_q;
  assign pix_x_o     = pix_x_q;
  assign pix_y_o     = pix_y_q;
  assign pix_data_o  = pix_data_q;

endmodule

// File: doc/st7789_spi_rx.md
ST7789_SPI_RX -- requirements
Module: st7789_spi_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 240, meaning the panel column count and the reset value of column end plus one.
REQ-002 SHALL have parameter HEIGHT, default 240, meaning the panel row count and the reset value of row end plus one.
REQ-003 SHALL have parameter IDLE_TIMEOUT, default 1024, meaning the number of clk_i cycles without a SCL rising edge after which the bit counter realigns.
REQ-004 SHALL have the port clk_i, input, 1 bit: the single clock, with every flop on its rising edge.
REQ-005 SHALL have the port rst_ni, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have the ports st7789_SDA, st7789_SCL, st7789_DC and st7789_RES, inputs, 1 bit each: asynchronous display-bus pins driven by the host.
REQ-007 SHALL have the port cmd_valid_o, output, 1 bit: a one-cycle pulse per received command byte.
REQ-008 SHALL have the port cmd_o, output, 8 bits: the last command byte received.
REQ-009 SHALL have the port pix_valid_o, output, 1 bit: a one-cycle pulse per completed RGB565 pixel.
REQ-010 SHALL have the ports pix_x_o and pix_y_o, outputs, 9 bits each: the pixel coordinates.
REQ-011 SHALL have the port pix_data_o, output, 16 bits: the pixel value, first byte in bits [15:8].

Function
REQ-012 SHALL pass SDA, SCL, DC and RES each through a two-flop synchronizer, reset value 1 for SCL and RES and 0 for the others.
REQ-013 SHALL detect a SCL rising edge as synchronized SCL = 1 with its previous value = 0.
- SPI mode 3, MSB first, no chip select.
- Host SCL high and low phases are each ≥ 3 clk_i cycles.
REQ-014 SHALL shift SDA into an 8-bit shift register on each SCL rising edge and advance a 3-bit bit counter, which wraps from 7 to 0.
REQ-015 SHALL form a byte when the counter wraps, tagging it with the synchronized DC sampled on that same edge.
REQ-016 SHALL reset the bit counter to 0 when IDLE_TIMEOUT consecutive cycles pass with no SCL rising edge.
- Any partial byte is discarded.
REQ-017 SHALL implement the FSM states IDLE, CASET, RASET, RAMWR and SKIP, plus a 2-bit parameter-byte counter.
REQ-018 SHALL, on any byte with DC = 0, treat that byte as a command:
- pulse cmd_valid_o and update cmd_o;
- abandon the current state, including any pending half pixel;
- go to CASET on 0x2A, RASET on 0x2B, RAMWR on 0x2C, and SKIP on any other value.
REQ-019 SHALL, in CASET, capture data bytes 0..3 as {xs[15:8], xs[7:0], xe[15:8], xe[7:0]}, keep bits [8:0] only, and return to IDLE after byte 3.
REQ-020 SHALL behave in RASET exactly as in CASET, but for ys and ye.
REQ-021 SHALL, on entry to RAMWR, set x = xs and y = ys.
- Data bytes pair into pixels: even byte → high, odd byte → low.
- Each odd byte issues one pixel.
REQ-022 SHALL advance the address after each pixel:
- x ≥ xe → x = xs, then y ≥ ye → y = ys, else y = y + 1;
- else x = x + 1.
- This covers the case xs > xe, which writes one pixel per row.
REQ-023 SHALL ignore data bytes in IDLE and SKIP, and data bytes beyond byte 3 in CASET or RASET.
REQ-024 SHALL assert cmd_valid_o and pix_valid_o, registered, exactly 4 clk_i cycles after the clk_i edge whose synchronizer input first samples the eighth SCL high.
- No back-pressure; each pulse lasts 1 cycle.
REQ-025 SHALL hold cmd_o, pix_x_o, pix_y_o and pix_data_o stable between pulses.
- pix_x_o and pix_y_o carry the address of the emitted pixel, before the advance.
REQ-026 SHALL treat synchronized RES = 0 as a panel hardware reset, with the same effect as rst_ni except for the synchronizers.
- It takes priority over any byte completing in the same cycle.

Reset
REQ-027 SHALL, on rst_ni = 0 at a clk_i edge, reset as follows:
- FSM = IDLE, counters = 0;
- xs = ys = 0, xe = WIDTH-1, ye = HEIGHT-1, x = y = 0;
- all outputs = 0.
REQ-028 SHALL apply reset mid-byte or mid-pixel with no pulse produced from the partial data.

Verification
REQ-029 SHALL have a bench cover: byte 0x2A with DC = 0 → one cmd_valid_o pulse, cmd_o = 0x2A, 4 cycles after the eighth SCL rise.
REQ-030 SHALL have a bench cover: CASET 00 0A 00 0B, RASET 00 05 00 05, RAMWR, then bytes F8 00 07 E0 00 1F → pixels (10,5)=F800, (11,5)=07E0, (10,5)=001F.
REQ-031 SHALL have a bench cover: after reset, RAMWR followed by 240×240 pixels → the last pixel at (239,239), and the next at (0,0).
REQ-032 SHALL have a bench cover: RAMWR, 3 data bytes, then command 0x00 → exactly one pixel, with no pulse for the orphan byte.
REQ-033 SHALL have a bench cover: 5 SCL bits, then an idle of IDLE_TIMEOUT cycles, then byte 0x2C → cmd_o = 0x2C, correctly aligned.
REQ-034 SHALL have a bench cover: RES pulled low for 10 cycles mid-RAMWR → no further pixels, window restored to 0..239.
